// File: rtl/wshb_pattern_pkg.sv
// Shared types and constants for the Wishbone test-pattern responder.
package wshb_pattern_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEEK,
    S_WAIT,
    S_BURST,
    S_ERR,
    S_WACK
  } state_e;

  typedef enum logic [1:0] {
    MODE_BARS,
    MODE_CHECK,
    MODE_GRAD,
    MODE_LINE
  } mode_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Entry 0 is the leftmost bar.
  localparam logic [7:0][23:0] BAR_RGB = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

endpackage

// File: rtl/pattern_pixel.sv
// Combinational pixel generator: coordinates, bar index and mode to 24-bit RGB.
module pattern_pixel
  import wshb_pattern_pkg::*;
#(
  parameter int XW = 10,
  parameter int YW = 9
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [2:0]    b,
  input  mode_e         mode,
  input  logic [7:0]    frame_cnt,
  output logic [23:0]   rgb
);

  logic [7:0] xe;
  logic [7:0] ye;

  // Narrow displays zero-extend so bits 5 and 7:0 always exist.
  always_comb begin
    xe = 8'(x);
    ye = 8'(y);
    case (mode)
      MODE_BARS:  rgb = BAR_RGB[b];
      MODE_CHECK: rgb = (xe[5] ^ ye[5]) ? 24'hFFFFFF : 24'h000000;
      MODE_GRAD:  rgb = {xe, ye, frame_cnt};
      default:    rgb = (xe == frame_cnt) ? 24'hFFFFFF : 24'h202020;
    endcase
  end

endmodule

// File: rtl/wshb_pattern_slave.sv
// Wishbone burst-read responder returning a synthetic test pattern in place of SDRAM.
module wshb_pattern_slave
  import wshb_pattern_pkg::*;
#(
  parameter int HDISP   = 800,
  parameter int VDISP   = 480,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] dat_ms,
  input  logic [3:0]  sel,
  input  logic [2:0]  cti,
  input  logic [1:0]  bte,
  output logic [31:0] dat_sm,
  output logic        ack,
  output logic        err,
  output logic        rty,
  output logic [7:0]  frame_cnt
);

  localparam int NPIX = HDISP * VDISP;
  localparam int BARW = HDISP / 8;
  localparam int XW   = $clog2(HDISP);
  localparam int YW   = $clog2(VDISP);
  localparam int NW   = $clog2(NPIX);
  localparam int LW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e          state;
  mode_e           mode;
  logic [NW-1:0]   nxt;
  logic [NW-1:0]   rem;
  logic [NW-1:0]   tgt;
  logic [XW-1:0]   x;
  logic [XW-1:0]   bc;
  logic [YW-1:0]   y;
  logic [2:0]      b;
  logic            seek_bar;
  logic [LW-1:0]   wcnt;

  logic [31:0]     idx;
  logic            req;
  logic            beat;
  logic            last_x;
  logic            last_pix;
  logic            bar_end;
  logic [XW-1:0]   px;
  logic [YW-1:0]   py;
  logic [2:0]      pb;
  logic [7:0]      pfc;
  logic [23:0]     rgb;
  logic            unused;

  assign idx    = {2'b00, adr[31:2]};
  assign req    = cyc & stb;
  assign beat   = req & (state == S_BURST);
  assign ack    = req & ((state == S_BURST) | (state == S_WACK));
  assign err    = req & (state == S_ERR);
  assign rty    = 1'b0;
  assign unused = ^{bte, sel[3:1], dat_ms[31:2], adr[1:0]};

  // Coordinates the pattern is evaluated at: the advanced pixel on an
  // accepted beat, otherwise the current one, so dat_sm lands with them.
  always_comb begin
    last_x   = (32'(x) == HDISP - 1);
    last_pix = last_x && (32'(y) == VDISP - 1);
    bar_end  = (32'(bc) == BARW - 1);
    px  = x;
    py  = y;
    pb  = b;
    pfc = frame_cnt;
    if (beat) begin
      if (last_x) begin
        px = '0;
        pb = '0;
        py = last_pix ? '0 : y + 1'b1;
        if (last_pix) pfc = frame_cnt + 8'd1;
      end else begin
        px = x + 1'b1;
        pb = bar_end ? b + 3'd1 : b;
      end
    end
  end

  pattern_pixel #(.XW(XW), .YW(YW)) u_pix (
    .x         (px),
    .y         (py),
    .b         (pb),
    .mode      (mode),
    .frame_cnt (pfc),
    .rgb       (rgb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mode      <= MODE_BARS;
      nxt       <= '0;
      rem       <= '0;
      tgt       <= '0;
      x         <= '0;
      bc        <= '0;
      y         <= '0;
      b         <= '0;
      seek_bar  <= 1'b0;
      wcnt      <= '0;
      frame_cnt <= '0;
      dat_sm    <= '0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          wcnt <= '0;
          if (idx >= 32'(NPIX)) begin
            state <= S_ERR;
          end else if (we) begin
            state <= S_WACK;
          end else if (idx == 32'(nxt)) begin
            state  <= (LATENCY == 0) ? S_BURST : S_WAIT;
            dat_sm <= {8'h00, rgb};
          end else begin
            state    <= S_SEEK;
            rem      <= NW'(adr[31:2]);
            tgt      <= NW'(adr[31:2]);
            y        <= '0;
            seek_bar <= 1'b0;
          end
        end

        // Two restoring-division passes: index/HDISP for y, then x/BARW for b.
        S_SEEK: if (!seek_bar) begin
          if (32'(rem) >= HDISP) begin
            rem <= rem - NW'(HDISP);
            y   <= y + 1'b1;
          end else begin
            x        <= XW'(rem);
            b        <= '0;
            seek_bar <= 1'b1;
          end
        end else begin
          if (32'(rem) >= BARW) begin
            rem <= rem - NW'(BARW);
            b   <= b + 3'd1;
          end else begin
            bc     <= XW'(rem);
            nxt    <= tgt;
            wcnt   <= '0;
            state  <= (LATENCY == 0) ? S_BURST : S_WAIT;
            dat_sm <= {8'h00, rgb};
          end
        end

        S_WAIT: begin
          dat_sm <= {8'h00, rgb};
          if (wcnt == LW'(LATENCY - 1)) state <= S_BURST;
          else                          wcnt  <= wcnt + 1'b1;
        end

        S_BURST: if (!req) begin
          state <= S_IDLE;
        end else begin
          x         <= px;
          y         <= py;
          b         <= pb;
          frame_cnt <= pfc;
          bc        <= (last_x || bar_end) ? '0 : bc + 1'b1;
          nxt       <= last_pix ? '0 : nxt + 1'b1;
          dat_sm    <= {8'h00, rgb};
          if (cti != CTI_INCR) state <= S_IDLE;
        end

        S_WACK: begin
          if (sel[0]) mode <= mode_e'(dat_ms[1:0]);
          state <= S_IDLE;
        end

        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wshb_pattern_slave.sv
// Scoreboard bench: the master driver queues expected responses from a pixel-level model, a monitor checks them.
module tb_wshb_pattern_slave;
  import wshb_pattern_pkg::*;

  localparam int HDISP   = 64;
  localparam int VDISP   = 16;
  localparam int LATENCY = 2;
  localparam int NPIX    = HDISP * VDISP;
  localparam int BARW    = HDISP / 8;
  localparam int K_RD = 0, K_WR = 1, K_ERR = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we;
  logic [31:0] adr, dat_ms;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_sm;
  logic        ack, err, rty;
  logic [7:0]  frame_cnt;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  // Reference state: next sequential pixel, pattern mode, frames completed.
  int m_nxt = 0, m_mode = 0, m_fc = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  wshb_pattern_slave #(.HDISP(HDISP), .VDISP(VDISP), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .cyc(cyc), .stb(stb), .we(we), .adr(adr),
    .dat_ms(dat_ms), .sel(sel), .cti(cti), .bte(bte), .dat_sm(dat_sm),
    .ack(ack), .err(err), .rty(rty), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pix(input int p, input int fc, input int md);
    int px, py;
    px = p % HDISP;
    py = p / HDISP;
    case (md)
      0: return {8'h00, bars[px / BARW]};
      1: return (((px >> 5) ^ (py >> 5)) & 1) != 0 ? 32'h00FFFFFF : 32'h00000000;
      2: return {8'h00, 8'(px), 8'(py), 8'(fc)};
      default: return ((px & 255) == (fc & 255)) ? 32'h00FFFFFF : 32'h00202020;
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && (ack || err)) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b dat=%h", ack, err, dat_sm);
      end else begin
        e = sb.pop_front();
        if (e.kind == K_ERR && !(err && !ack)) begin
          bad++;
          $display("FAIL err_resp: ack=%0b err=%0b expected err only", ack, err);
        end else if (e.kind == K_WR && !(ack && !err)) begin
          bad++;
          $display("FAIL wr_resp: ack=%0b err=%0b expected ack only", ack, err);
        end else if (e.kind == K_RD && (!ack || err || dat_sm !== e.data)) begin
          bad++;
          $display("FAIL rd_data: ack=%0b err=%0b dat=%h expected %h", ack, err, dat_sm, e.data);
        end
      end
    end
  end

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Single-beat transaction answered by ack (write) or err; both take one cycle.
  task automatic single(input int idx, input bit w, input logic [31:0] d, input logic [3:0] s);
    int cnt = 0;
    bit got = 0;
    cyc = 1; stb = 1; we = w; adr = 32'(idx) << 2; dat_ms = d; sel = s; cti = CTI_CLASSIC;
    while (!got && cnt < 50) begin
      @(negedge clk); cnt++;
      if (ack || err) got = 1;
      @(posedge clk); #1;
    end
    cyc = 0; stb = 0; we = 0;
    check("single_latency", got ? cnt : -1, 2);
    idle_cycle();
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.data = '0;
    if (idx >= NPIX) e.kind = K_ERR;
    else begin
      e.kind = K_WR;
      if (s[0]) m_mode = int'(d[1:0]);
    end
    sb.push_back(e);
    single(idx, 1'b1, d, s);
  endtask

  task automatic rd(input int idx, input int n, input bit eob);
    int cnt, beats, first, last, seek, p;
    exp_t e;
    if (idx >= NPIX) begin
      e.kind = K_ERR; e.data = '0;
      sb.push_back(e);
      single(idx, 1'b0, '0, 4'hF);
      return;
    end
    seek = (idx == m_nxt) ? 0 : idx / HDISP + (idx % HDISP) / BARW + 2;
    p = idx;
    for (int i = 0; i < n; i++) begin
      e.kind = K_RD; e.data = pix(p, m_fc, m_mode);
      sb.push_back(e);
      p++;
      if (p == NPIX) begin p = 0; m_fc = (m_fc + 1) % 256; end
    end
    m_nxt = p;
    cyc = 1; stb = 1; we = 0; adr = 32'(idx) << 2; sel = 4'hF;
    cti = (eob && n == 1) ? CTI_CLASSIC : CTI_INCR;
    cnt = 0; beats = 0; first = 0; last = 0;
    while (beats < n && cnt < n + 100) begin
      @(negedge clk); cnt++;
      if (ack) begin
        beats++;
        if (first == 0) first = cnt;
        last = cnt;
      end
      @(posedge clk); #1;
      if (eob && beats == n - 1) cti = CTI_EOB;
    end
    cyc = 0; stb = 0; cti = CTI_CLASSIC;
    check("rd_first_ack", first, seek + LATENCY + 2);
    check("rd_beats", beats, n);
    check("rd_no_gap", last - first, n - 1);
    idle_cycle();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int beats, cnt, r, idx;
    exp_t e;
    rst = 1; cyc = 0; stb = 0; we = 0; adr = '0; dat_ms = '0; sel = '0;
    cti = CTI_CLASSIC; bte = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", int'(ack), 0);
    check("rst_err", int'(err), 0);
    check("rst_rty", int'(rty), 0);
    check("rst_dat", int'(dat_sm), 0);
    check("rst_frame", int'(frame_cnt), 0);
    @(posedge clk); #1 rst = 0;
    idle_cycle();

    // Sequential burst from pixel 0, then continuation with no seek.
    rd(0, 16, 1);
    rd(16, 4, 1);
    // Pattern write then a read needing one line of seek.
    wr(0, 32'd2, 4'b0001);
    rd(HDISP + 1, 3, 1);
    // Write with sel[0] clear leaves mode alone.
    wr(5, 32'd3, 4'b1110);
    rd(HDISP + 4, 2, 1);
    // Master drops stb mid-burst; resume where it stopped.
    rd(0, 5, 0);
    rd(5, 4, 1);
    // Out-of-range read: error only, sequential position kept.
    rd(NPIX, 1, 1);
    rd(9, 3, 1);
    // Whole frame plus wrap into the next one.
    rd(0, NPIX + 4, 1);
    check("frame_cnt_wrap", int'(frame_cnt), m_fc);

    for (int t = 0; t < 30; t++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        idx = (r == 0) ? NPIX + $urandom_range(0, 8) : $urandom_range(0, NPIX - 1);
        wr(idx, $urandom, 4'($urandom_range(0, 15)));
      end else begin
        if (r < 5)       idx = m_nxt;
        else if (r == 9) idx = NPIX + $urandom_range(0, 40);
        else             idx = $urandom_range(0, NPIX - 1);
        rd(idx, $urandom_range(1, 20), 1'($urandom_range(0, 1)));
      end
      check("frame_cnt", int'(frame_cnt), m_fc);
    end

    // Reset in the middle of a burst.
    wr(0, 32'd1, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      e.kind = K_RD; e.data = pix((m_nxt + i) % NPIX, m_fc, m_mode);
      sb.push_back(e);
    end
    cyc = 1; stb = 1; we = 0; adr = 32'(m_nxt) << 2; cti = CTI_INCR;
    beats = 0; cnt = 0;
    while (beats < 3 && cnt < 100) begin
      @(negedge clk); cnt++;
      if (ack) beats++;
      if (beats < 3) begin @(posedge clk); #1; end
    end
    check("pre_rst_beats", beats, 3);
    #1 rst = 1;
    @(posedge clk);
    @(negedge clk);
    check("rst_burst_ack", int'(ack), 0);
    check("rst_burst_frame", int'(frame_cnt), 0);
    @(posedge clk); #1;
    rst = 0; cyc = 0; stb = 0; cti = CTI_CLASSIC;
    m_nxt = 0; m_mode = 0; m_fc = 0;
    idle_cycle();
    rd(2 * BARW + 3, 10, 1);
    rd(m_nxt, 6, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wshb_pattern_slave.md
# wshb_pattern_slave

Wishbone responder at the other end of the display read path. It answers the display controller's incrementing-burst reads with a synthetic HDISP×VDISP test pattern, generated on the fly from tracked pixel coordinates, in place of the SDRAM. It lets the video pipeline be brought up and verified without the memory controller. Single-beat writes select the pattern.

## Interface
- HDISP, 800: pixels per line; must be a multiple of 8
- VDISP, 480: lines per frame
- LATENCY, 2: wait states (0..15) between cycle start and first ack
- clk  in  1  Wishbone clock
- rst  in  1  synchronous, active-high reset
- cyc  in  1  bus cycle
- stb  in  1  strobe
- we  in  1  write enable
- adr  in  32  byte address; pixel index = adr[31:2]
- dat_ms  in  32  write data
- sel  in  4  byte selects
- cti  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
- bte  in  2  burst type; must be 00 (linear); other values ignored
- dat_sm  out  32  read data {8'h00, R, G, B}
- ack  out  1  acknowledge
- err  out  1  error: index ≥ HDISP*VDISP
- rty  out  1  tied 0
- frame_cnt  out  8  completed-frame counter

## Operation
- Request: cyc & stb in IDLE. Beat accepted when ack & cyc & stb.
- Internal state:
  - next index NXT, initially 0
  - coordinates x, y
  - bar index b (0..7) and bar sub-count
  - mode[1:0]
- FSM states: IDLE, SEEK, WAIT, BURST, ERR, WACK. Transitions out of IDLE:
  - index ≥ HDISP*VDISP → ERR
  - we → WACK
  - read, index == NXT → WAIT
  - read, index ≠ NXT → SEEK
- SEEK: restoring divider. Load rem = index, y = 0. Each cycle, if rem ≥ HDISP then rem -= HDISP and y++; otherwise x = rem, b = x/(HDISP/8) via the same loop, NXT = index, go to WAIT. Cost: floor(index/HDISP) + floor(x/(HDISP/8)) + 2 cycles.
- WAIT: count LATENCY cycles, loading dat_sm for (x, y); then BURST. With LATENCY = 0, go straight to BURST.
- BURST: ack = cyc & stb. The address is ignored after the first beat. On each accepted beat:
  - x, b, NXT advance
  - x wraps at HDISP with y++
  - past the last pixel, NXT, x, y → 0 and frame_cnt++ (mod 256)
  - dat_sm is updated for the new coordinates on the same edge
- BURST exit to IDLE on any of:
  - accepted beat with cti ≠ 010
  - stb low
  - cyc low
- WACK: ack for one cycle. If sel[0], mode ← dat_ms[1:0]. No other state changes. Return to IDLE.
- ERR: err for one cycle, no state change; IDLE.
- Patterns (x, y, b):
  - mode 0, colour bars by b: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000
  - mode 1, checker: x[5]^y[5] ? FFFFFF : 000000
  - mode 2, gradient: {x[7:0], y[7:0], frame_cnt}
  - mode 3, moving line: x[7:0] == frame_cnt ? FFFFFF : 202020
- Width rules:
  - x: $clog2(HDISP) bits; y: $clog2(VDISP) bits; NXT and rem: $clog2(HDISP*VDISP) bits
  - comparisons are done at 32 bits before truncation

## Timing
- Reset values:
  - ack = err = rty = 0, dat_sm = 0, frame_cnt = 0
  - mode = 0, NXT = x = y = b = 0
  - FSM = IDLE
- Reset mid-burst: the next cycle is IDLE with ack low.
- ack and err are registered FSM state gated combinationally with cyc & stb, so they drop in the same cycle the master drops stb.
- Sequential read latency: first ack in cycle LATENCY+1 after the request. Reads then continue at one beat per clock.
- Write and error latency: one cycle.
- A new request is sampled no earlier than one cycle after returning to IDLE.
- A burst crossing the frame end wraps to pixel 0 with no gap.

## Structure
- Package wshb_pattern_pkg:
  - state enum
  - CTI constants: CLASSIC, INCR, EOB
  - 24-bit bar colour table
  - pattern-mode enum
- One sub-module: pattern_pixel, combinational (x, y, b, mode, frame_cnt) → 24-bit RGB; registered by the parent.

## Test plan
- Reset, then incrementing burst at adr 0 for 16 beats, LATENCY = 2, mode 0 → first ack in cycle 3; dat_sm = 00FFFFFF ×16; then NXT = 16.
- Single write dat_ms = 2 with sel = 1, then a read at adr 4*(801) → SEEK takes 1 + 0 + 2 cycles plus LATENCY; dat_sm = {8'h00, 8'h01, 8'h01, 8'h00}.
- Full frame of 384000 beats starting at 0 → frame_cnt 0→1 on the last beat; next beat returns pixel 0 without a wait state.
- Read at adr 4*384000 → err for one cycle, no ack; NXT unchanged.
- Drop stb mid-burst after 5 beats, re-request at adr 20 → no SEEK (index matches NXT); only LATENCY waits.
- Assert rst during BURST → ack = 0 on the next cycle; frame_cnt = 0; mode = 0.
